// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and the round engine.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;
    typedef logic [3:0]   aes_rnd_t;

    // Round constants, indexed by round number 1..10.
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, 8-bit in / 8-bit out.
// Purely combinational, no flow control.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry 0 sits in the most significant byte, so the table index is ~din.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[~din];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry key file.
// 10 cycles from start acceptance to keys_ready; start is ignored while busy.
// Optional AES_KEYEXP_ZEROIZE_EN: clears rk[1..10] on start and masks reads while busy.
module aes_key_expand
    import aes_pkg::aes_word_t, aes_pkg::aes_block_t, aes_pkg::aes_rnd_t, aes_pkg::RCON;
#(
    parameter int NR     = 10,
    parameter bit RD_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  aes_block_t   key,
    output logic         busy,
    output logic         keys_ready,
    output logic         done,
    input  aes_rnd_t     rk_idx,
    output aes_block_t   rk_data
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    logic [0:0] state;
    aes_rnd_t   r;
    aes_block_t work;
    aes_block_t next_rk;
    aes_block_t rk_file [0:NR];
    aes_block_t rd_val;
    aes_word_t  w0, w1, w2, w3;
    aes_word_t  rot, sub, t;
    aes_word_t  n0, n1, n2, n3;
    logic       accept;

    assign accept = (state == IDLE) && start;
    assign busy   = (state == EXPAND);

    // work mirrors rk[r-1] so the round function never goes through the key-file mux.
    assign {w0, w1, w2, w3} = work;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot[8*i +: 8]),
            .dout (sub[8*i +: 8])
        );
    end

    assign t  = sub ^ {RCON[r], 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r          <= '0;
            work       <= '0;
            keys_ready <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                rk_file[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk_file[0] <= key;
                        work       <= key;
                        r          <= 4'd1;
                        keys_ready <= 1'b0;
                        state      <= EXPAND;
`ifdef AES_KEYEXP_ZEROIZE_EN
                        for (int i = 1; i <= NR; i++) begin
                            rk_file[i] <= '0;
                        end
`endif
                    end
                end
                EXPAND: begin
                    rk_file[r] <= next_rk;
                    work       <= next_rk;
                    r          <= r + 4'd1;
                    if (r == aes_rnd_t'(NR)) begin
                        state      <= IDLE;
                        keys_ready <= 1'b1;
                        done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        if (rk_idx <= aes_rnd_t'(NR)) begin
            rd_val = rk_file[rk_idx];
        end
`ifdef AES_KEYEXP_ZEROIZE_EN
        // Masking on the accepting cycle too keeps the registered port from latching stale keys.
        if (busy || accept) begin
            rd_val = '0;
        end
`endif
    end

    if (RD_REG) begin : g_rd_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rk_data <= '0;
            end else begin
                rk_data <= rd_val;
            end
        end
    end else begin : g_rd_comb
        assign rk_data = rd_val;
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboarded bench for aes_key_expand; reference schedule built from a GF(2^8) S-box model.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         keys_ready;
    logic         done;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int lat;

    logic [127:0] sb_q [$];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_K2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_K3 = 128'hffeeddccbbaa99887766554433221100;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10), .RD_REG(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .keys_ready (keys_ready),
        .done       (done),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {ref_sbox(tmp[23:16]), ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0]),
                       ref_sbox(tmp[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j <= 10; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    task automatic read_rk(input int idx, input logic [127:0] want, input string tag);
        sb_q.push_back(want);
        rk_idx = 4'(idx);
        @(posedge clk);
        @(negedge clk);
        chk(tag, rk_data, sb_q.pop_front());
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i <= 10; i++) read_rk(i, exp_rk[i], $sformatf("%s_rk%0d", tag, i));
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic run_expand(input logic [127:0] k, input bit noise, output int cycles);
        start = 1'b1;
        key   = k;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("busy_after_accept", {127'b0, busy}, 128'd1);
        chk("keys_ready_drop", {127'b0, keys_ready}, 128'd0);
        cycles = 0;
        while (!done && cycles < 30) begin
            if (noise) begin
                start = (cycles == 2 || cycles == 6);
                key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key    = '0;
        rk_idx = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_keys_ready", {127'b0, keys_ready}, 128'd0);
        chk("rst_done", {127'b0, done}, 128'd0);
        chk("rst_rk_data", rk_data, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 vector, latency and done pulse width
        run_expand(KEY_A1, 1'b0, lat);
        chk("a1_latency", 128'(lat), 128'd10);
        chk("a1_done_hi", {127'b0, done}, 128'd1);
        chk("a1_busy_lo", {127'b0, busy}, 128'd0);
        @(negedge clk);
        chk("a1_done_width", {127'b0, done}, 128'd0);
        chk("a1_keys_ready", {127'b0, keys_ready}, 128'd1);
        read_rk(1, 128'ha0fafe1788542cb123a339392a6c7605, "a1_fips_rk1");
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a1_fips_rk10");
        model_expand(KEY_A1);
        check_all("a1");

        // All-zero key
        run_expand(128'h0, 1'b0, lat);
        chk("zero_latency", 128'(lat), 128'd10);
        read_rk(1, 128'h62636363626363636263636362636363, "zero_rk1");
        read_rk(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        // start pulses mid-expansion with other keys must be ignored
        run_expand(KEY_K1, 1'b1, lat);
        chk("ign_latency", 128'(lat), 128'd10);
        model_expand(KEY_K1);
        check_all("ign");

        // Back-to-back: second start in the cycle right after done
        run_expand(KEY_K2, 1'b0, lat);
        chk("b2b_first_latency", 128'(lat), 128'd10);
        run_expand(KEY_K3, 1'b0, lat);
        chk("b2b_second_latency", 128'(lat), 128'd10);
        chk("b2b_keys_ready", {127'b0, keys_ready}, 128'd1);
        model_expand(KEY_K3);
        check_all("b2b");

        // Reset in the middle of an expansion
        start = 1'b1;
        key   = KEY_K2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {127'b0, busy}, 128'd0);
        chk("mid_rst_keys_ready", {127'b0, keys_ready}, 128'd0);
        chk("mid_rst_done", {127'b0, done}, 128'd0);
        chk("mid_rst_rk_data", rk_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 10; i++) read_rk(i, 128'h0, $sformatf("mid_rst_rk%0d", i));
        run_expand(KEY_A1, 1'b0, lat);
        chk("post_rst_latency", 128'(lat), 128'd10);
        read_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_rst_rk10");

        // Out-of-range indices
        read_rk(11, 128'h0, "idx11");
        read_rk(15, 128'h0, "idx15");

`ifdef AES_KEYEXP_ZEROIZE_EN
        start = 1'b1;
        key   = KEY_K1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rk_idx = 4'(k + 1);
            chk($sformatf("zeroize_busy_%0d", k), rk_data, 128'h0);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
